uart_receiver: RTL and testbench
================================

# uart_receiver

Receive half of the board UART. It deserializes 8N1 frames from the `UART_RX` pin, which is already routed through `top`, and presents each byte on a valid/ready holding register for the command logic. It is the counterpart of `uart_tx`: the bench drives `uart_tx` into `UART_RX`, and `uart_receiver` must recover those bytes bit-exactly.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz (`CLK_OSC100`).
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT`, derived as `CLK_FREQ/BAUD` with integer division (868 at the defaults). Elaboration fails if it is below 8.
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  asynchronous reset, active-high.
- `uart_rx`  in  1  asynchronous serial input. Idle level is high.
- `rx_valid`  out  1  holding register contains a byte.
- `rx_ready`  in  1  consumer accepts the byte.
- `rx_data`  out  8  received byte, LSB first on the line.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_overrun`  out  1  one-cycle pulse when a byte is dropped because the holding register is full.

## Operation
- `uart_rx` passes through a 2-FF synchronizer whose flops reset to 1. All logic below sees only the synchronized line `rxs`.
- FSM states: WAIT_IDLE, IDLE, START, DATA, STOP.
  - Reset enters WAIT_IDLE.
  - WAIT_IDLE → IDLE on the first cycle with `rxs`=1. This prevents a mid-frame reset from decoding garbage.
  - IDLE → START when `rxs`=0. The bit counter `cnt` clears to 0 that cycle.
  - START: sample at `cnt`=HALF, where HALF = `CLKS_PER_BIT/2`. A sample of 0 goes to DATA; a sample of 1 is a glitch and goes to IDLE with no output.
  - DATA: samples every `CLKS_PER_BIT` cycles and shifts each bit into the MSB of the shift register. It goes to STOP after 8 bits.
  - STOP: one sample `CLKS_PER_BIT` after the last data bit.
    - Sample 1 delivers the byte and goes to IDLE.
    - Sample 0 pulses `rx_frame_err`, does not deliver the byte, and goes to WAIT_IDLE. This covers a break condition.
- Counters:
  - `cnt` is 16 bits wide, counts from 0 to `CLKS_PER_BIT-1`, and wraps to 0 at each sample tick.
  - The data-bit index is 3 bits wide.
- Holding register, one byte deep. On delivery:
  - `rx_valid`=0, or `rx_valid & rx_ready` in the same cycle: load `rx_data`, `rx_valid`=1, no overrun.
  - `rx_valid`=1 and `rx_ready`=0: keep the old byte, discard the new one, pulse `rx_overrun`.
- `rx_valid` clears on the edge after a cycle with `rx_valid & rx_ready`.
- `rx_ready` is ignored when `rx_valid`=0.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_data`=8'h00, `rx_frame_err`=0, `rx_overrun`=0.
  - FSM in WAIT_IDLE, `cnt`=0, synchronizer flops = 1.
- Reset is asynchronous on assertion. Deassertion is taken synchronously by the parent reset logic.
- Let T0 be the cycle in which IDLE sees `rxs`=0.
  - Start-bit sample at T0+HALF.
  - Data bit i (i = 0..7) sampled at T0+HALF+(i+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at T0+HALF+9·`CLKS_PER_BIT`.
- `rx_valid` or `rx_frame_err` is registered one cycle after the stop sample.
  - At the defaults this is T0+8247.
  - T0 itself lags the pin edge by 2 or 3 cycles.
- A new start bit is accepted in the cycle after STOP exits to IDLE, so back-to-back frames lose no data.
- `rx_overrun` and `rx_frame_err` never assert in the same cycle.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Every sample point, including the start-bit check, uses the 2-of-3 majority of `rxs` at offsets −1, 0 and +1 around the sample tick.
  - The decision is taken at tick+1. The timing above shifts by +1 cycle.
- `UART_RX_MAJORITY_EN` undefined: a single sample of `rxs` at the tick.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - Constants `UART_DATA_BITS`=8 and `UART_MIN_CLKS_PER_BIT`=8.
  - Helper function `clks_per_bit(CLK_FREQ, BAUD)`, which is reused by `uart_tx`.
- One sub-module: `uart_sync2`, a 2-FF synchronizer with a parameterized reset value. Set it to 1 here.

## Test plan
- Send 8'h48 ("H") at 115200 bit/s with `rx_ready`=1 → one cycle with `rx_valid`=1 and `rx_data`=8'h48, within 8250 cycles of the start edge. No error pulses.
- Send 8'h48 then 8'h65 ("e") back-to-back with no idle gap, `rx_ready`=1 → two deliveries in order, 8'h48 then 8'h65.
- Drive a 200-cycle low glitch on the idle line → no `rx_valid` and no error. A following 8'h5A frame is received correctly.
- Send a frame with 8'h3C and the stop bit forced low, then hold the line low for 2 frames → exactly one `rx_frame_err` pulse and no `rx_valid`. The next valid 8'hA5 is received.
- Hold `rx_ready`=0 and send 8'h11 then 8'h22 → `rx_data` stays 8'h11 and `rx_overrun` pulses once at the second stop bit. Raising `rx_ready` clears `rx_valid`.
- Assert `reset` in the middle of data bit 3 → all outputs go to their reset values immediately. After deassertion nothing is delivered until the line has been high. The next 8'hC3 frame is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame constants and baud-divisor helper.
// The helper is also used by uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_MIN_CLKS_PER_BIT = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample tick.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rx,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [7:0]          rx_data,
    output logic                rx_frame_err,
    output logic                rx_overrun,
    output uart_rx_state_t      rx_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF         = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_LAG   = 1;
`else
    localparam int SAMPLE_LAG   = 0;
`endif
    localparam logic [15:0] START_TICK = 16'(HALF + SAMPLE_LAG);
    localparam logic [15:0] BIT_TICK   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT   = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) begin : g_bad_divisor
        $error("uart_receiver: CLKS_PER_BIT below minimum");
    end

    logic rxs;
    logic sample_d;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (uart_rx),
        .q_o   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rxs_q1;
    logic rxs_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxs_q1 <= 1'b1;
            rxs_q2 <= 1'b1;
        end else begin
            rxs_q1 <= rxs;
            rxs_q2 <= rxs_q1;
        end
    end

    // Evaluated one cycle after the nominal tick: rxs, rxs_q1, rxs_q2 are offsets +1, 0, -1.
    assign sample_d = (rxs & rxs_q1) | (rxs & rxs_q2) | (rxs_q1 & rxs_q2);
`else
    assign sample_d = rxs;
`endif

    uart_rx_state_t state_q;
    logic [15:0]    cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           valid_q;
    logic [7:0]     data_q;
    logic           ferr_q;
    logic           ovr_q;

    // Handshake: a byte transfers in any cycle with rx_valid & rx_ready; rx_valid then
    // drops on the next edge unless a new byte is loaded in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    // cnt is 0 in the start-edge cycle, so the next cycle counts 1.
                    if (!rxs) begin
                        state_q <= START;
                        cnt_q   <= 16'd1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                START: begin
                    if (cnt_q == START_TICK) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= sample_d ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_TICK) begin
                        cnt_q     <= '0;
                        shift_q   <= {sample_d, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_TICK) begin
                        cnt_q <= '0;
                        if (sample_d) begin
                            state_q <= IDLE;
                            if (!valid_q || rx_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= WAIT_IDLE;
                end
            endcase
        end
    end

    assign rx_valid     = valid_q;
    assign rx_data      = data_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_state     = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 32 clocks per bit: frames, glitch, framing error,
// overrun and mid-frame reset, with a byte scoreboard fed by the line driver.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;

    logic           clk;
    logic           reset;
    logic           uart_rx;
    logic           rx_valid;
    logic           rx_ready;
    logic [7:0]     rx_data;
    logic           rx_frame_err;
    logic           rx_overrun;
    uart_rx_state_t rx_state;

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_state     (rx_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_vcyc   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int last_rise_cyc = 0;
    logic valid_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) n_vcyc++;
            if (rx_valid && !valid_prev) last_rise_cyc = cyc;
            if (rx_frame_err) n_ferr++;
            if (rx_overrun) n_ovr++;
            if (rx_valid && rx_ready) begin
                n_hs++;
                check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        valid_prev = rx_valid;
    end

    // driver tasks; every task starts and ends 1 ns after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
    endtask

    int hs0, vc0, fe0, ov0, t_start, lat;

    task automatic snap();
        hs0 = n_hs; vc0 = n_vcyc; fe0 = n_ferr; ov0 = n_ovr;
    endtask

    initial begin
        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        idle(4);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        check("rst_ovr", 32'(rx_overrun), 32'd0);
        check("rst_state", 32'(rx_state), 32'(WAIT_IDLE));
        reset = 1'b0;
        idle(2 * CPB);

        // single byte, latency window and one-cycle valid
        snap();
        exp_q.push_back(8'h48);
        t_start = cyc;
        send_byte(8'h48, 1'b1);
        idle(4);
        lat = last_rise_cyc - t_start;
        check("latency_window", 32'(lat >= HALF + 9 * CPB + 2 && lat <= HALF + 9 * CPB + 4), 32'd1);
        check("h_deliveries", 32'(n_hs - hs0), 32'd1);
        check("h_valid_cycles", 32'(n_vcyc - vc0), 32'd1);
        check("h_no_ferr", 32'(n_ferr - fe0), 32'd0);
        check("h_no_ovr", 32'(n_ovr - ov0), 32'd0);

        // back-to-back frames
        snap();
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h65);
        send_byte(8'h48, 1'b1);
        send_byte(8'h65, 1'b1);
        idle(4);
        check("b2b_deliveries", 32'(n_hs - hs0), 32'd2);

        // short glitch is rejected at the start-bit check
        snap();
        uart_rx = 1'b0;
        idle(6);
        uart_rx = 1'b1;
        idle(3 * CPB);
        check("glitch_no_valid", 32'(n_vcyc - vc0), 32'd0);
        check("glitch_no_ferr", 32'(n_ferr - fe0), 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(4);
        check("glitch_then_5a", 32'(n_hs - hs0), 32'd1);

        // framing error followed by a break
        snap();
        send_byte(8'h3C, 1'b0);
        uart_rx = 1'b0;
        idle(20 * CPB);
        uart_rx = 1'b1;
        idle(2 * CPB);
        check("ferr_pulses", 32'(n_ferr - fe0), 32'd1);
        check("ferr_no_valid", 32'(n_vcyc - vc0), 32'd0);
        check("ferr_no_ovr", 32'(n_ovr - ov0), 32'd0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        idle(4);
        check("ferr_then_a5", 32'(n_hs - hs0), 32'd1);

        // overrun with consumer stalled
        snap();
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        check("ovr_first_valid", 32'(rx_valid), 32'd1);
        check("ovr_no_pulse_yet", 32'(n_ovr - ov0), 32'd0);
        send_byte(8'h22, 1'b1);
        idle(4);
        check("ovr_pulses", 32'(n_ovr - ov0), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_no_ferr", 32'(n_ferr - fe0), 32'd0);
        rx_ready = 1'b1;
        idle(1);
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        check("ovr_one_delivery", 32'(n_hs - hs0), 32'd1);

        // asynchronous reset in the middle of data bit 3, with a byte held
        rx_ready = 1'b0;
        exp_q.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        idle(4);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        exp_q.delete();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        uart_rx = 1'b1;
        idle(HALF);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'h00);
        check("midrst_ferr", 32'(rx_frame_err), 32'd0);
        check("midrst_ovr", 32'(rx_overrun), 32'd0);
        check("midrst_state", 32'(rx_state), 32'(WAIT_IDLE));
        idle(2);
        reset = 1'b0;
        rx_ready = 1'b1;
        snap();
        for (int i = 4; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        idle(2 * CPB);
        check("postrst_no_valid", 32'(n_vcyc - vc0), 32'd0);
        check("postrst_no_ferr", 32'(n_ferr - fe0), 32'd0);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        idle(4);
        check("postrst_c3", 32'(n_hs - hs0), 32'd1);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
